axi3_mem_slave: RTL and testbench

AXI3_MEM_SLAVE -- requirements
Module: axi3_mem_slave

---
 rtl/axi3_mem_slave_if.sv | 67 ++++++
 rtl/axi3_mem_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_axi3_mem_slave.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi3_mem_slave_if.sv
// AXI3 read and write channel bundles for the single-word memory responder.
// The ID width is carried as a parameter so master and slave agree on arid/rid and awid/wid/bid.
interface axi3_rd_if #(
   parameter int BUS_WIDTH = 4
);
   logic [31:0]          araddr;
   logic [3:0]           arlen;
   logic [2:0]           arsize;
   logic [1:0]           arburst;
   logic [1:0]           arlock;
   logic [3:0]           arcache;
   logic [2:0]           arprot;
   logic [BUS_WIDTH-1:0] arid;
   logic                 arvalid;
   logic                 arready;
   logic [31:0]          rdata;
   logic [1:0]           rresp;
   logic                 rlast;
   logic [BUS_WIDTH-1:0] rid;
   logic                 rvalid;
   logic                 rready;

   modport master (
      output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid, arvalid, rready,
      input  arready, rdata, rresp, rlast, rid, rvalid
   );
   modport slave (
      input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid, arvalid, rready,
      output arready, rdata, rresp, rlast, rid, rvalid
   );
endinterface

interface axi3_wr_if #(
   parameter int BUS_WIDTH = 4
);
   logic [31:0]          awaddr;
   logic [3:0]           awlen;
   logic [2:0]           awsize;
   logic [1:0]           awburst;
   logic [1:0]           awlock;
   logic [3:0]           awcache;
   logic [2:0]           awprot;
   logic [BUS_WIDTH-1:0] awid;
   logic                 awvalid;
   logic                 awready;
   logic [31:0]          wdata;
   logic [3:0]           wstrb;
   logic                 wlast;
   logic [BUS_WIDTH-1:0] wid;
   logic                 wvalid;
   logic                 wready;
   logic [1:0]           bresp;
   logic [BUS_WIDTH-1:0] bid;
   logic                 bvalid;
   logic                 bready;

   modport master (
      output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awid, awvalid,
      output wdata, wstrb, wlast, wid, wvalid, bready,
      input  awready, wready, bresp, bid, bvalid
   );
   modport slave (
      input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awid, awvalid,
      input  wdata, wstrb, wlast, wid, wvalid, bready,
      output awready, wready, bresp, bid, bvalid
   );
endinterface

// File: rtl/axi3_mem_slave.sv
// AXI3 memory responder: 32-bit word RAM with independent single-outstanding read and write FSMs.
// Beats outside the RAM window answer SLVERR and never touch memory.
//
// state    | meaning
// ---------+----------------------------------------------------------
// R_IDLE   | read side waiting for an AR handshake (arready high)
// R_BURST  | read beats being presented, one word per rready handshake
// W_IDLE   | write side waiting for an AW handshake (awready high)
// W_DATA   | accepting write beats (wready high)
// W_RESP   | holding the B response until bready
module axi3_mem_slave #(
   parameter int          BUS_WIDTH = 4,
   parameter int          MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic     clk,
   input  logic     rst,
   axi3_rd_if.slave rd,
   axi3_wr_if.slave wr
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [31:0] mem_q [MEM_WORDS];

   function automatic logic in_range(input logic [31:0] a);
      logic [32:0] off;
      off = {1'b0, a} - {1'b0, BASE_ADDR};
      return (a >= BASE_ADDR) && (off < MEM_BYTES);
   endfunction

   function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
      return AW'((a - BASE_ADDR) >> 2);
   endfunction

   // WRAP only honoured for power-of-two beat counts; anything else falls back to INCR.
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                             input logic [1:0] burst);
      logic [31:0] inc;
      logic [31:0] mask;
      logic [31:0] res;
      inc  = a + 32'd4;
      mask = {26'd0, len, 2'b11};
      res  = inc;
      if (burst == 2'b00) begin
         res = a;
      end else if (burst == 2'b10 && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
         res = (a & ~mask) | (inc & mask);
      end
      return res;
   endfunction

   // ---------------- read side ----------------
   r_state_t             r_state_q, r_state_d;
   logic [31:0]          r_addr_q, r_addr_d;
   logic [3:0]           r_len_q, r_len_d;
   logic [1:0]           r_burst_q, r_burst_d;
   logic [BUS_WIDTH-1:0] r_id_q, r_id_d;
   logic [3:0]           r_cnt_q, r_cnt_d;
   logic                 r_busy;
   logic                 r_ok;

   always_comb begin
      r_state_d = r_state_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_burst_d = r_burst_q;
      r_id_d    = r_id_q;
      r_cnt_d   = r_cnt_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (rd.arvalid) begin
               r_addr_d  = {rd.araddr[31:2], 2'b00};
               r_len_d   = rd.arlen;
               r_burst_d = rd.arburst;
               r_id_d    = rd.arid;
               r_cnt_d   = 4'd0;
               r_state_d = R_BURST;
            end
         end
         R_BURST: begin
            if (rd.rready) begin
               if (r_cnt_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
                  r_cnt_d  = r_cnt_q + 4'd1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_burst_q <= '0;
         r_id_q    <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_burst_q <= r_burst_d;
         r_id_q    <= r_id_d;
         r_cnt_q   <= r_cnt_d;
      end
   end

   // Outputs come from registered state only, gated so everything reads zero while rst is held.
   assign r_busy     = (r_state_q == R_BURST) && !rst;
   assign r_ok       = in_range(r_addr_q);
   assign rd.arready = (r_state_q == R_IDLE) && !rst;
   assign rd.rvalid  = r_busy;
   assign rd.rlast   = r_busy && (r_cnt_q == r_len_q);
   assign rd.rid     = r_busy ? r_id_q : '0;
   assign rd.rresp   = (r_busy && !r_ok) ? 2'b10 : 2'b00;
   assign rd.rdata   = (r_busy && r_ok) ? mem_q[word_idx(r_addr_q)] : 32'd0;

   // ---------------- write side ----------------
   w_state_t             w_state_q, w_state_d;
   logic [31:0]          w_addr_q, w_addr_d;
   logic [3:0]           w_len_q, w_len_d;
   logic [1:0]           w_burst_q, w_burst_d;
   logic [BUS_WIDTH-1:0] w_id_q, w_id_d;
   logic [3:0]           w_cnt_q, w_cnt_d;
   logic                 w_err_q, w_err_d;
   logic                 w_ok;
   logic                 w_end;
   logic                 mem_we;

   assign w_ok  = in_range(w_addr_q);
   assign w_end = (w_cnt_q == w_len_q);

   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_len_d   = w_len_q;
      w_burst_d = w_burst_q;
      w_id_d    = w_id_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      mem_we    = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (wr.awvalid) begin
               w_addr_d  = {wr.awaddr[31:2], 2'b00};
               w_len_d   = wr.awlen;
               w_burst_d = wr.awburst;
               w_id_d    = wr.awid;
               w_cnt_d   = 4'd0;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wr.wvalid) begin
               mem_we  = w_ok && !rst;
               w_err_d = w_err_q || !w_ok;
               // A burst ends on wlast or on the programmed length; disagreement is flagged.
               if (wr.wlast || w_end) begin
                  w_state_d = W_RESP;
                  if (wr.wlast != w_end) w_err_d = 1'b1;
               end else begin
                  w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                  w_cnt_d  = w_cnt_q + 4'd1;
               end
            end
         end
         W_RESP: begin
            if (wr.bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_burst_q <= '0;
         w_id_q    <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_burst_q <= w_burst_d;
         w_id_q    <= w_id_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
      end
   end

   assign wr.awready = (w_state_q == W_IDLE) && !rst;
   assign wr.wready  = (w_state_q == W_DATA) && !rst;
   assign wr.bvalid  = (w_state_q == W_RESP) && !rst;
   assign wr.bid     = ((w_state_q == W_RESP) && !rst) ? w_id_q : '0;
   assign wr.bresp   = ((w_state_q == W_RESP) && !rst && w_err_q) ? 2'b10 : 2'b00;

   // RAM contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wr.wstrb[i]) mem_q[word_idx(w_addr_q)][8*i +: 8] <= wr.wdata[8*i +: 8];
         end
      end
   end

   logic sig_unused;
   assign sig_unused = ^{rd.araddr[1:0], rd.arsize, rd.arlock, rd.arcache, rd.arprot,
                         wr.awaddr[1:0], wr.awsize, wr.awlock, wr.awcache, wr.awprot, wr.wid};

endmodule

// File: tb/tb_axi3_mem_slave.sv
// Directed bench for axi3_mem_slave: hand-computed bursts covering INCR/WRAP/FIXED, strobes,
// stalls, out-of-range SLVERR, early wlast and reset mid-burst.
module tb_axi3_mem_slave;

   logic clk = 1'b0;
   logic rst;
   int   n_vec  = 0;
   int   n_miss = 0;

   axi3_rd_if #(.BUS_WIDTH(4)) rd_bus ();
   axi3_wr_if #(.BUS_WIDTH(4)) wr_bus ();

   axi3_mem_slave #(.BUS_WIDTH(4), .MEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .rd  (rd_bus),
      .wr  (wr_bus)
   );

   always #5 clk = ~clk;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_id;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   logic [31:0] ex [4];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_burst(input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input logic [3:0] id, input int wl_beat);
      int t;
      wr_bus.awaddr  = addr;
      wr_bus.awlen   = len;
      wr_bus.awburst = burst;
      wr_bus.awid    = id;
      wr_bus.awvalid = 1'b1;
      t = 0;
      while (!wr_bus.awready && t < 50) begin tick(); t++; end
      if (t >= 50) check_val("aw_timeout", 32'(wr_bus.awready), 32'd1);
      tick();
      wr_bus.awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wr_bus.wdata  = wd[b];
         wr_bus.wstrb  = ws[b];
         wr_bus.wlast  = (b == wl_beat);
         wr_bus.wvalid = 1'b1;
         t = 0;
         while (!wr_bus.wready && t < 50) begin tick(); t++; end
         if (t >= 50) check_val("w_timeout", 32'(wr_bus.wready), 32'd1);
         tick();
         if (b == wl_beat) break;
      end
      wr_bus.wvalid = 1'b0;
      wr_bus.wlast  = 1'b0;
      wr_bus.bready = 1'b1;
      t = 0;
      while (!wr_bus.bvalid && t < 50) begin tick(); t++; end
      if (t >= 50) check_val("b_timeout", 32'(wr_bus.bvalid), 32'd1);
      b_resp = wr_bus.bresp;
      b_id   = wr_bus.bid;
      tick();
      wr_bus.bready = 1'b0;
      check_val("b_single", 32'(wr_bus.bvalid), 32'd0);
   endtask

   task automatic read_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input logic [3:0] id);
      int t;
      rd_bus.araddr  = addr;
      rd_bus.arlen   = len;
      rd_bus.arburst = burst;
      rd_bus.arid    = id;
      rd_bus.arvalid = 1'b1;
      t = 0;
      while (!rd_bus.arready && t < 50) begin tick(); t++; end
      if (t >= 50) check_val("ar_timeout", 32'(rd_bus.arready), 32'd1);
      tick();
      rd_bus.arvalid = 1'b0;
      rd_bus.rready  = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         t = 0;
         while (!rd_bus.rvalid && t < 50) begin tick(); t++; end
         if (t >= 50) check_val("r_timeout", 32'(rd_bus.rvalid), 32'd1);
         rd_data[b] = rd_bus.rdata;
         rd_resp[b] = rd_bus.rresp;
         rd_last[b] = rd_bus.rlast;
         rd_id      = rd_bus.rid;
         tick();
      end
      rd_bus.rready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rd_bus.araddr = '0; rd_bus.arlen = '0; rd_bus.arsize = 3'd2; rd_bus.arburst = 2'b01;
      rd_bus.arlock = '0; rd_bus.arcache = '0; rd_bus.arprot = '0; rd_bus.arid = '0;
      rd_bus.arvalid = 1'b0; rd_bus.rready = 1'b0;
      wr_bus.awaddr = '0; wr_bus.awlen = '0; wr_bus.awsize = 3'd2; wr_bus.awburst = 2'b01;
      wr_bus.awlock = '0; wr_bus.awcache = '0; wr_bus.awprot = '0; wr_bus.awid = '0;
      wr_bus.awvalid = 1'b0; wr_bus.wdata = '0; wr_bus.wstrb = '0; wr_bus.wlast = 1'b0;
      wr_bus.wid = '0; wr_bus.wvalid = 1'b0; wr_bus.bready = 1'b0;

      // reset values
      repeat (2) tick();
      check_val("rst_arready", 32'(rd_bus.arready), 32'd0);
      check_val("rst_awready", 32'(wr_bus.awready), 32'd0);
      check_val("rst_wready",  32'(wr_bus.wready),  32'd0);
      check_val("rst_rvalid",  32'(rd_bus.rvalid),  32'd0);
      check_val("rst_bvalid",  32'(wr_bus.bvalid),  32'd0);
      check_val("rst_rdata",   rd_bus.rdata,        32'd0);
      rst = 1'b0;
      #1;
      check_val("post_rst_arready", 32'(rd_bus.arready), 32'd1);
      check_val("post_rst_awready", 32'(wr_bus.awready), 32'd1);
      tick();

      // INCR write then read back
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      write_burst(32'h10, 4'd3, 2'b01, 4'd5, 3);
      check_val("incr_bresp", 32'(b_resp), 32'd0);
      check_val("incr_bid",   32'(b_id),   32'd5);
      read_burst(32'h10, 4'd3, 2'b01, 4'd9);
      for (int i = 0; i < 4; i++) begin
         check_val("incr_rdata", rd_data[i], 32'hA0 + 32'(i));
         check_val("incr_rlast", 32'(rd_last[i]), (i == 3) ? 32'd1 : 32'd0);
         check_val("incr_rresp", 32'(rd_resp[i]), 32'd0);
      end
      check_val("incr_rid", 32'(rd_id), 32'd9);

      // WRAP 0x18 len 3 -> 0x18,0x1C,0x10,0x14
      ex[0] = 32'hA2; ex[1] = 32'hA3; ex[2] = 32'hA0; ex[3] = 32'hA1;
      read_burst(32'h18, 4'd3, 2'b10, 4'd1);
      for (int i = 0; i < 4; i++) check_val("wrap_rdata", rd_data[i], ex[i]);
      check_val("wrap_rlast", 32'(rd_last[3]), 32'd1);

      // FIXED stays on one word
      read_burst(32'h14, 4'd2, 2'b00, 4'd2);
      for (int i = 0; i < 3; i++) check_val("fixed_rdata", rd_data[i], 32'hA1);

      // reserved burst behaves as INCR
      read_burst(32'h10, 4'd1, 2'b11, 4'd3);
      check_val("rsvd_rdata0", rd_data[0], 32'hA0);
      check_val("rsvd_rdata1", rd_data[1], 32'hA1);

      // WRAP with len 2 behaves as INCR
      read_burst(32'h14, 4'd2, 2'b10, 4'd4);
      check_val("wrap3_rdata0", rd_data[0], 32'hA1);
      check_val("wrap3_rdata1", rd_data[1], 32'hA2);
      check_val("wrap3_rdata2", rd_data[2], 32'hA3);

      // byte strobes
      wd[0] = 32'h1122_3344; ws[0] = 4'hF;
      write_burst(32'h40, 4'd0, 2'b01, 4'd6, 0);
      wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
      write_burst(32'h40, 4'd0, 2'b01, 4'd6, 0);
      read_burst(32'h40, 4'd0, 2'b01, 4'd6);
      check_val("strb_rdata", rd_data[0], 32'h11BB_33DD);
      check_val("strb_rlast", 32'(rd_last[0]), 32'd1);

      // rready stall mid-burst
      rd_bus.araddr = 32'h10; rd_bus.arlen = 4'd3; rd_bus.arburst = 2'b01; rd_bus.arid = 4'd7;
      rd_bus.arvalid = 1'b1;
      tick();
      rd_bus.arvalid = 1'b0;
      check_val("stall_first", rd_bus.rdata, 32'hA0);
      rd_bus.rready = 1'b1;
      tick();
      rd_bus.rready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_val("stall_rdata",  rd_bus.rdata, 32'hA1);
         check_val("stall_rlast",  32'(rd_bus.rlast),  32'd0);
         check_val("stall_rid",    32'(rd_bus.rid),    32'd7);
         check_val("stall_rvalid", 32'(rd_bus.rvalid), 32'd1);
         tick();
      end
      rd_bus.rready = 1'b1;
      for (int b = 1; b < 4; b++) begin
         check_val("stall_resume", rd_bus.rdata, 32'hA0 + 32'(b));
         check_val("stall_rlast2", 32'(rd_bus.rlast), (b == 3) ? 32'd1 : 32'd0);
         tick();
      end
      rd_bus.rready = 1'b0;
      check_val("stall_done", 32'(rd_bus.rvalid), 32'd0);

      // out of range: first byte past the RAM, and a burst crossing the top
      read_burst(32'h1000, 4'd0, 2'b01, 4'd2);
      check_val("oor_rresp", 32'(rd_resp[0]), 32'd2);
      check_val("oor_rdata", rd_data[0], 32'd0);
      wd[0] = 32'h5555_AAAA; ws[0] = 4'hF;
      wd[1] = 32'h0000_0001; ws[1] = 4'hF;
      write_burst(32'hFFC, 4'd1, 2'b01, 4'd3, 1);
      check_val("oor_bresp", 32'(b_resp), 32'd2);
      read_burst(32'hFFC, 4'd1, 2'b01, 4'd3);
      check_val("top_rdata", rd_data[0], 32'h5555_AAAA);
      check_val("top_rresp", 32'(rd_resp[0]), 32'd0);
      check_val("cross_rresp", 32'(rd_resp[1]), 32'd2);
      check_val("cross_rdata", rd_data[1], 32'd0);

      // early wlast: 4th word keeps its old value
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
      write_burst(32'h80, 4'd3, 2'b01, 4'd1, 3);
      check_val("pre_bresp", 32'(b_resp), 32'd0);
      for (int i = 0; i < 4; i++) wd[i] = 32'hC0 + 32'(i);
      write_burst(32'h80, 4'd3, 2'b01, 4'd8, 2);
      check_val("early_bresp", 32'(b_resp), 32'd2);
      check_val("early_bid",   32'(b_id),   32'd8);
      read_burst(32'h80, 4'd3, 2'b01, 4'd1);
      check_val("early_w0", rd_data[0], 32'hC0);
      check_val("early_w1", rd_data[1], 32'hC1);
      check_val("early_w2", rd_data[2], 32'hC2);
      check_val("early_w3", rd_data[3], 32'hB3);

      // wlast missing on the final counted beat
      wd[0] = 32'hD0; wd[1] = 32'hD1;
      write_burst(32'hC0, 4'd1, 2'b01, 4'd2, -1);
      check_val("nolast_bresp", 32'(b_resp), 32'd2);

      // reset during beat 0 of a 4-beat read
      rd_bus.araddr = 32'h10; rd_bus.arlen = 4'd3; rd_bus.arburst = 2'b01; rd_bus.arid = 4'd2;
      rd_bus.arvalid = 1'b1;
      tick();
      rd_bus.arvalid = 1'b0;
      check_val("mid_rvalid", 32'(rd_bus.rvalid), 32'd1);
      rst = 1'b1;
      tick();
      check_val("mid_rst_rvalid",  32'(rd_bus.rvalid),  32'd0);
      check_val("mid_rst_arready", 32'(rd_bus.arready), 32'd0);
      rst = 1'b0;
      #1;
      check_val("mid_post_arready", 32'(rd_bus.arready), 32'd1);
      check_val("mid_post_rvalid",  32'(rd_bus.rvalid),  32'd0);
      tick();
      read_burst(32'h10, 4'd1, 2'b01, 4'd0);
      check_val("mem_intact0", rd_data[0], 32'hA0);
      check_val("mem_intact1", rd_data[1], 32'hA1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
